// File: rtl/pipe_pkg.sv
// Shared definitions for the core pipeline stage registers: skid-stage state
// encoding and the payload width of every inter-stage boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 294;
  localparam int EX_MEM_W = 160;
  localparam int MEM_WB_W = 104;

  function automatic logic holds_beat(input stage_state_e s);
    return (s != EMPTY);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// sat_counter: enable-gated up counter that sticks at all-ones instead of
// wrapping. Cleared only by the asynchronous reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline stage with a two-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_STALL_CNT_EN to build the saturating stall-cycle counter.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH          = 294,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_e     r_state;
  stage_state_e     w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_out_valid;
  logic w_in_ready;
  logic w_accept;
  logic w_drain;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_accept = in_valid & w_in_ready;
  assign w_drain  = w_out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) w_state_nxt = HALF;
        HALF: begin
          if (w_accept && !w_drain)      w_state_nxt = FULL;
          else if (!w_accept && w_drain) w_state_nxt = EMPTY;
        end
        FULL:    if (w_drain) w_state_nxt = HALF;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs depend on the state register alone, so in_ready has no
  // combinational path from out_ready.
  always_comb begin
    w_out_valid      = holds_beat(r_state);
    w_in_ready       = (r_state != FULL);
    w_load_main_in   = w_accept && ((r_state == EMPTY) || ((r_state == HALF) && w_drain));
    w_load_main_skid = (r_state == FULL) && w_drain;
    w_load_skid      = w_accept && (r_state == HALF) && !w_drain;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      if (w_load_main_in) begin
        r_main <= in_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

  assign out_valid = w_out_valid;
  assign in_ready  = w_in_ready;
  assign out_data  = r_main;

`ifdef PIPE_STAGE_STALL_CNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_out_valid & ~out_ready),
    .o_cnt (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: FIFO scoreboard plus directed
// scenarios for streaming, back-pressure, flush, async reset and stall count.
module tb_pipe_stage_skid_reg;
  import pipe_pkg::*;

  localparam int W  = ID_EX_W;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_ready;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [W-1:0]  out_data1, out_data0;
  logic [CW-1:0] stall1, stall0;

  int n_vec  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .stall_cnt(stall1));

  pipe_stage_skid_reg #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b0), .CNT_W(CW)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .stall_cnt(stall0));

  // Scoreboard: a two-deep FIFO model predicts handshake and head payload.
  always @(negedge clk) begin
    logic exp_rdy;
    logic exp_vld;
    if (mon_en && !reset) begin
      exp_rdy = (q.size() < 2);
      exp_vld = (q.size() > 0);
      n_vec++;
      if (in_ready1 !== exp_rdy) begin
        n_fail++;
        $display("FAIL sb_in_ready t=%0t got %b want %b", $time, in_ready1, exp_rdy);
      end
      n_vec++;
      if (out_valid1 !== exp_vld) begin
        n_fail++;
        $display("FAIL sb_out_valid t=%0t got %b want %b", $time, out_valid1, exp_vld);
      end
      if (exp_vld) begin
        n_vec++;
        if (out_data1 !== q[0]) begin
          n_fail++;
          $display("FAIL sb_out_data t=%0t got %h want %h", $time, out_data1, q[0]);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && exp_rdy) q.push_back(in_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    n_vec++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready1); end
    n_vec++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid1); end
    n_vec++; if (out_data1 !== '0) begin n_fail++; $display("FAIL rst_out_data got %h want 0", out_data1); end
    n_vec++; if (out_data0 !== '0) begin n_fail++; $display("FAIL rst_out_data0 got %h want 0", out_data0); end
    n_vec++; if (stall1 !== '0) begin n_fail++; $display("FAIL rst_stall got %0d want 0", stall1); end
    @(negedge clk); #1;
    reset = 1'b0;
    q.delete();
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      tick();
      n_vec++;
      if (out_valid1 !== 1'b1 || out_data1 !== W'(i) || in_ready1 !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_beat%0d got v=%b rdy=%b d=%h want v=1 rdy=1 d=%0d",
                 i, out_valid1, in_ready1, out_data1, i);
      end
    end
    in_valid = 1'b0;
    tick();
    n_vec++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", out_valid1); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'('hA); tick();
    in_data = W'('hB); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || out_data1 !== W'('hA)) begin
        n_fail++;
        $display("FAIL bp_full_hold%0d got rdy=%b v=%b d=%h want rdy=0 v=1 d=a",
                 i, in_ready1, out_valid1, out_data1);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_data1 !== W'('hB) || out_valid1 !== 1'b1 || in_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_drain got d=%h v=%b rdy=%b want d=b v=1 rdy=1", out_data1, out_valid1, in_ready1);
    end
    tick();
    n_vec++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", out_valid1); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'('h5); tick();
    in_data = W'('h6); tick();
    in_data = W'('hC); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || out_data1 !== '0) begin
      n_fail++;
      $display("FAIL flush_full got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", out_valid1, in_ready1, out_data1);
    end
    n_vec++;
    if (out_valid0 !== 1'b0 || out_data0 !== W'('h5)) begin
      n_fail++;
      $display("FAIL flush_noclear got v=%b d=%h want v=0 d=5", out_valid0, out_data0);
    end
    // A beat offered while in_ready=1 on the flush cycle must be dropped.
    in_valid = 1'b1; in_data = W'('h7); tick();
    in_data = W'('hD); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_discard%0d got v1=%b v0=%b want 0 0", i, out_valid1, out_valid0);
      end
      tick();
    end
    n_vec++;
    if (out_data0 !== W'('h7)) begin n_fail++; $display("FAIL flush_noclear_stale got %h want 7", out_data0); end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    for (int i = 0; i < 300; i++) begin
      d = '0;
      for (int k = 0; k < 10; k++) d = (d << 32) | W'($urandom());
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = d;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle();
    tick(); tick(); tick();
    n_vec++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL rand_drain got %b want 0", out_valid1); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('h77); tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL ar_half got %b want 1", out_valid1); end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || out_data1 !== '0 || out_data0 !== '0) begin
      n_fail++;
      $display("FAIL ar_immediate got v=%b rdy=%b d1=%h d0=%h want 0 1 0 0", out_valid1, in_ready1, out_data1, out_data0);
    end
    n_vec++; if (stall1 !== '0) begin n_fail++; $display("FAIL ar_stall got %0d want 0", stall1); end
    @(negedge clk); #1;
    reset = 1'b0;
    q.delete();
    tick();
  endtask

  task automatic test_stall_cnt();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('h99); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
`ifdef PIPE_STAGE_STALL_CNT_EN
    n_vec++; if (stall1 !== 4'hF) begin n_fail++; $display("FAIL stall_sat got %0d want 15", stall1); end
    flush = 1'b1; tick(); flush = 1'b0; tick();
    n_vec++; if (stall1 !== 4'hF) begin n_fail++; $display("FAIL stall_flush got %0d want 15", stall1); end
    #2 reset = 1'b1; #1;
    n_vec++; if (stall1 !== '0) begin n_fail++; $display("FAIL stall_reset got %0d want 0", stall1); end
    @(negedge clk); #1;
    reset = 1'b0;
    q.delete();
    tick();
`else
    n_vec++; if (stall1 !== '0) begin n_fail++; $display("FAIL stall_tieoff got %0d want 0", stall1); end
    flush = 1'b1; tick(); flush = 1'b0; tick();
`endif
  endtask

  initial begin
    test_reset();
    test_streaming();
    idle(); tick();
    test_back_to_back();
    idle(); tick();
    test_flush();
    idle(); tick();
    test_random();
    test_async_reset();
    test_stall_cnt();
    idle(); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised pipeline stage register that replaces fixed-width, enable-less stage registers between core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, a two-entry skid buffer so that in_ready is a pure register output, and a synchronous flush.
- Full throughput of one beat per cycle. A back-pressured stage never drops or duplicates a beat.

Parameters:
- WIDTH, 294, payload width in bits.
- CLEAR_ON_FLUSH, 1, when 1, flush and reset zero both payload registers; when 0, only valid state is cleared.
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous squash of every held and incoming beat.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; registered, decoded from state only.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  beat presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload; always equals the main register.
- stall_cnt  out  CNT_W  stall-cycle count (PIPE_STAGE_STALL_CNT_EN only; tie-off 0 otherwise).

Behaviour:
- Clock is clk; reset is reset, asynchronous, active-high.
- Storage:
  - main register: the visible entry.
  - skid register: overflow entry.
  - state ∈ {EMPTY, HALF, FULL}.
- Signal definitions:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- Output decode:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - out_data = main.
- Reset values (asynchronous): state=EMPTY, main=0, skid=0, out_valid=0, in_ready=1, out_data=0, stall_cnt=0.
- Transitions when flush=0:
  - EMPTY: accept → HALF, main<=in_data. No accept → stay EMPTY.
  - HALF, accept & drain: stay HALF, main<=in_data (back-to-back streaming).
  - HALF, accept & !drain: → FULL, skid<=in_data, main holds.
  - HALF, !accept & drain: → EMPTY.
  - HALF, neither: hold.
  - FULL: accept is impossible because in_ready=0. drain → HALF, main<=skid. No drain → hold both registers.
- Flush:
  - Highest priority after reset. Next state is EMPTY regardless of accept or drain in the same cycle.
  - A beat offered on the flush cycle is discarded, even though in_ready may read 1 in that cycle.
  - A drain coinciding with flush still counts as consumed by downstream; this stage takes no further action on it.
  - CLEAR_ON_FLUSH=1: main and skid are zeroed. CLEAR_ON_FLUSH=0: payloads hold stale values, but out_valid=0.
- Latency and throughput:
  - Latency is 1 cycle from accept in EMPTY (or HALF with drain) to out_valid.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
  - Order is strictly FIFO (main before skid).
- Stability rule: while out_valid=1 and out_ready=0, out_data and out_valid hold. Payload is never altered under stall.
- Reset mid-operation: all beats are lost and the stage returns to EMPTY immediately, asynchronously.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- Defined: stall_cnt increments on every cycle with out_valid=1 and out_ready=0. It saturates at all-ones with no wrap. It is cleared by reset only; flush does not clear it.
- Undefined: no counter flops are built and stall_cnt is driven to constant 0. Port list is unchanged so instantiations need no edits.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding typedef/localparams (EMPTY=2'd0, HALF=2'd1, FULL=2'd2);
  - per-stage payload width constants (IF_ID_W, ID_EX_W=294, EX_MEM_W, MEM_WB_W) so every stage instantiates from one source.
- One natural sub-module, sat_counter (CNT_W, enable, saturating), used only under the macro. Everything else stays flat.

Test Plan:
- Streaming: out_ready=1, in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles → out_data 0x1,0x2,0x3 one cycle later each; in_ready stays 1; state never reaches FULL.
- Back-pressure: send 0xA, 0xB with out_ready=0 → FULL, in_ready=0, out_data=0xA held; raise out_ready for 2 cycles → 0xA then 0xB, no loss or duplicate; in_ready returns to 1 after the first drain.
- Flush in FULL with in_valid=1 carrying 0xC → next cycle EMPTY, out_valid=0, in_ready=1; with CLEAR_ON_FLUSH=1, out_data=0; 0xC never appears at the output.
- Flush with CLEAR_ON_FLUSH=0 → out_valid=0 while out_data retains the prior payload.
- Async reset asserted mid-cycle in HALF → out_valid=0, in_ready=1, out_data=0 without waiting for clk.
- With PIPE_STAGE_STALL_CNT_EN and CNT_W=4: hold a beat stalled for 20 cycles → stall_cnt saturates at 15. A flush leaves it at 15; reset clears it to 0.
